// File: rtl/ltssm_detect_seq.sv
// Detect-phase sequencer: steps through Detect.Quiet and Detect.Active, issues PIPE receiver
// detection, drives the LTSSM timeout timer, and reports success or persistent failure.
module ltssm_detect_seq #(
  parameter int DETECT_RETRY_MAX = 2,
  parameter int CNT_W            = 4
) (
  input  logic             Pclk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             ElecIdleExit,
  input  logic             RxDetDone,
  input  logic             RxDetected,
  input  logic             TimeOut,
  output logic             TimerStart,
  output logic             TimerEnable,
  output logic [2:0]       TimerIntervalCode,
  output logic             TxDetectRx,
  output logic             DetectDone,
  output logic             DetectFail,
  output logic [CNT_W-1:0] FailCount,
  output logic [2:0]       DetectState
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_QUIET  = 3'b001,
    ST_ACTIVE = 3'b010,
    ST_DONE   = 3'b011,
    ST_FAIL   = 3'b100
  } state_t;

  localparam logic [2:0] CODE_IDLE = 3'b000;
  localparam logic [2:0] CODE_12MS = 3'b001;
  localparam logic [2:0] CODE_1MS  = 3'b110;

  state_t            state_reg, state_next;
  logic              timer_start_reg, timer_start_next;
  logic [CNT_W-1:0]  fail_count_reg, fail_count_next;
  logic [CNT_W-1:0]  fail_inc;
  logic              qual_timeout;

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      state_reg       <= ST_IDLE;
      timer_start_reg <= 1'b0;
      fail_count_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      timer_start_reg <= timer_start_next;
      fail_count_reg  <= fail_count_next;
    end
  end

  // The timer holds TimeOut low in the start cycle; masking here keeps us safe regardless.
  assign qual_timeout = TimeOut & ~timer_start_reg;
  assign fail_inc     = (fail_count_reg == '1) ? fail_count_reg : fail_count_reg + CNT_W'(1);

  always_comb begin
    state_next      = state_reg;
    fail_count_next = fail_count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (Enable) state_next = ST_QUIET;
      end
      ST_QUIET: begin
        if (qual_timeout || ElecIdleExit) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (RxDetDone && RxDetected) begin
          state_next = ST_DONE;
        end else if (RxDetDone || qual_timeout) begin
          fail_count_next = fail_inc;
          state_next      = (fail_inc == CNT_W'(DETECT_RETRY_MAX)) ? ST_FAIL : ST_QUIET;
        end
      end
      ST_DONE, ST_FAIL: state_next = state_reg;
      default:          state_next = ST_IDLE;
    endcase

    if (!Enable) state_next = ST_IDLE;

    if (state_next == ST_IDLE || state_next == ST_DONE) fail_count_next = '0;

    // Pulse on every fresh entry into a timed state, including ACTIVE -> QUIET retries.
    timer_start_next = (state_next != state_reg) &&
                       (state_next == ST_QUIET || state_next == ST_ACTIVE);
  end

  always_comb begin
    TimerEnable       = 1'b0;
    TimerIntervalCode = CODE_IDLE;
    TxDetectRx        = 1'b0;
    DetectDone        = 1'b0;
    DetectFail        = 1'b0;
    case (state_reg)
      ST_QUIET: begin
        TimerEnable       = 1'b1;
        TimerIntervalCode = CODE_12MS;
      end
      ST_ACTIVE: begin
        TimerEnable       = 1'b1;
        TimerIntervalCode = CODE_1MS;
        TxDetectRx        = 1'b1;
      end
      ST_DONE: DetectDone = 1'b1;
      ST_FAIL: DetectFail = 1'b1;
      default: ;
    endcase
  end

  assign TimerStart  = timer_start_reg;
  assign FailCount   = fail_count_reg;
  assign DetectState = state_reg;

endmodule

// File: doc/ltssm_detect_seq.md
# ltssm_detect_seq

Detect-phase sequencer that sits on the requesting side of the LTSSM timeout timer. It drives the timer's start, enable and interval code. It sequences Detect.Quiet and Detect.Active, issues PIPE receiver detection, and reports either detection success (hand-off to Polling) or persistent failure to the top-level LTSSM.

## Interface
Parameters:
- DETECT_RETRY_MAX, 2, consecutive failed receiver detections before DetectFail; legal range 1..15.
- CNT_W, 4, width of FailCount.

Ports:
- Pclk  in  1  PIPE clock.
- Reset  in  1  synchronous, active-low.
- Enable  in  1  top-level LTSSM is in Detect; level.
- ElecIdleExit  in  1  any lane left electrical idle; level.
- RxDetDone  in  1  PhyStatus pulse completing a receiver-detect request.
- RxDetected  in  1  receiver present (RxStatus==3'b011); valid only with RxDetDone.
- TimeOut  in  1  timer expiry; combinational from timer, forced 0 by timer while TimerStart=1.
- TimerStart  out  1  one-cycle clear of the timer tick counter.
- TimerEnable  out  1  timer count enable.
- TimerIntervalCode  out  3  001=12 ms, 110=1 ms, 000=idle.
- TxDetectRx  out  1  PIPE receiver-detect request.
- DetectDone  out  1  receiver found; level until Enable drops.
- DetectFail  out  1  retry limit reached; level until Enable drops.
- FailCount  out  CNT_W  consecutive failed detections in the current Enable window.
- DetectState  out  3  current state encoding, for debug.

## Operation
- States: IDLE=000, QUIET=001, ACTIVE=010, DONE=011, FAIL=100. Moore outputs are decoded from registered state.
- IDLE:
  - All outputs 0.
  - Enable=1 -> QUIET.
- QUIET:
  - TimerIntervalCode=001, TimerEnable=1.
  - Exit to ACTIVE on qualified TimeOut or ElecIdleExit=1.
- ACTIVE:
  - TimerIntervalCode=110 (1 ms watchdog), TimerEnable=1, TxDetectRx=1.
  - RxDetDone=1 with RxDetected=1 -> DONE.
  - RxDetDone=1 with RxDetected=0 counts as a failure.
  - Qualified TimeOut with RxDetDone=0 counts as a failure (PHY did not respond).
  - On failure: FailCount+1. If the new value equals DETECT_RETRY_MAX -> FAIL, else -> QUIET.
- DONE: DetectDone=1, TimerEnable=0, code 000. Stays until Enable=0.
- FAIL: DetectFail=1, TimerEnable=0, code 000. Stays until Enable=0.
- TimerStart:
  - Registered flag, high for exactly the first cycle of every entry into QUIET or ACTIVE, including QUIET entered from ACTIVE on a retry.
  - Never high in IDLE, DONE or FAIL.
- Qualified TimeOut = TimeOut & ~TimerStart. TimeOut in the start cycle is always ignored.
- FailCount:
  - Cleared on reset and on every IDLE entry.
  - Cleared on entry to DONE.
  - Never wraps.

## Timing
- Reset (Reset=0 at a Pclk edge):
  - State IDLE.
  - TimerStart, TimerEnable, TxDetectRx, DetectDone, DetectFail = 0.
  - TimerIntervalCode=000, FailCount=0, DetectState=000.
- Reset mid-operation aborts immediately; TxDetectRx drops on the same edge.
- Enable=0 in any non-IDLE state -> IDLE on the next edge. This has priority over all other transitions. All outputs read 0 one cycle after Enable falls.
- Enable rises at edge N -> at N+1: DetectState=QUIET, TimerStart=1, TimerEnable=1, code 001.
- Transition latency: a qualified event at edge N -> new state and its outputs at N+1. TimerStart=1 at N+1 if the new state is QUIET or ACTIVE.
- TxDetectRx rises with ACTIVE entry and falls on the edge after RxDetDone. It never stays high outside ACTIVE.
- Simultaneous events:
  - RxDetDone and TimeOut in ACTIVE: RxDetDone wins, and RxDetected decides the outcome.
  - ElecIdleExit and TimeOut in QUIET: single transition to ACTIVE.
- RxDetDone outside ACTIVE is ignored.
- ElecIdleExit outside QUIET is ignored.

## Test plan
- Reset with Enable=1 held:
  - Required: all outputs 0 during reset.
  - Release reset -> QUIET after 1 cycle, with TimerStart pulsed 1 cycle and code 001.
- Clean detect:
  - Stimulus: TimeOut in QUIET, then RxDetDone=1 with RxDetected=1, 5 cycles into ACTIVE.
  - Required: TxDetectRx high 5 cycles; DetectDone=1 the next cycle; FailCount=0.
- One retry (DETECT_RETRY_MAX=2):
  - Stimulus: RxDetDone with RxDetected=0.
  - Required: FailCount=1, back to QUIET with a fresh TimerStart.
  - Stimulus: second attempt succeeds.
  - Required: DONE, FailCount cleared.
- Fail path:
  - Stimulus: two ACTIVE watchdog TimeOuts with no RxDetDone.
  - Required: FAIL, DetectFail=1, FailCount=2.
  - Stimulus: Enable=0.
  - Required: all outputs 0 one cycle later.
- TimeOut held high during TimerStart cycles:
  - Required: no transition in the start cycle; the transition occurs the cycle after.
- Enable dropped mid-ACTIVE:
  - Required: TxDetectRx=0 and IDLE next cycle.
  - Stimulus: RxDetDone one cycle later.
  - Required: ignored.
